// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider (result = data1 / data2), restoring division, denormals flushed; FPU_DIV_RNE_EN selects RNE rounding, else truncation.
// Latency: specials visible 1 cycle after accept, normal operands 26/BITS_PER_CYCLE+1 cycles.
// Backpressure: one op in flight; in_ready only in IDLE; result and flags held in DONE until out_ready.
module fp32_div_seq #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [31:0] QNAN           = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);
    localparam int STEPS = 26 / BITS_PER_CYCLE;
`ifdef FPU_DIV_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
    state_t state, state_nxt;

    logic              sign;
    logic signed [9:0] exp_t;
    logic [23:0]       mant_b;
    logic [24:0]       rem;
    logic [25:0]       quo;
    logic [4:0]        cnt;

    logic [7:0] e1, e2;
    logic       z1, z2, i1, i2, n1, n2;
    assign e1 = data1[30:23];
    assign e2 = data2[30:23];
    assign z1 = (e1 == 8'h00);
    assign z2 = (e2 == 8'h00);
    assign i1 = (e1 == 8'hFF) && (data1[22:0] == 23'h0);
    assign i2 = (e2 == 8'hFF) && (data2[22:0] == 23'h0);
    assign n1 = (e1 == 8'hFF) && (data1[22:0] != 23'h0);
    assign n2 = (e2 == 8'hFF) && (data2[22:0] != 23'h0);

    logic        sp_hit, sp_inv, sp_dbz, sp_sign;
    logic [31:0] sp_res;
    always_comb begin
        sp_sign = data1[31] ^ data2[31];
        sp_hit  = 1'b1;
        sp_inv  = 1'b0;
        sp_dbz  = 1'b0;
        sp_res  = '0;
        if (n1 || n2) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if ((z1 && z2) || (i1 && i2)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (i1) begin
            sp_res = {sp_sign, 8'hFF, 23'h0};
        end else if (i2) begin
            sp_res = {sp_sign, 31'h0};
        end else if (z2) begin
            sp_res = {sp_sign, 8'hFF, 23'h0};
            sp_dbz = 1'b1;
        end else if (z1) begin
            sp_res = {sp_sign, 31'h0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // The accept cycle already retires the first quotient bit(s) from the raw inputs.
    logic [24:0] it_rem;
    logic [25:0] it_quo;
    logic [23:0] it_div;
    logic [23:0] it_diff;
    always_comb begin
        if (state == IDLE) begin
            it_rem = {2'b01, data1[22:0]};
            it_div = {1'b1, data2[22:0]};
            it_quo = '0;
        end else begin
            it_rem = rem;
            it_div = mant_b;
            it_quo = quo;
        end
        it_diff = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            it_diff = it_rem[23:0] - it_div;
            if (it_rem >= {1'b0, it_div}) begin
                it_quo = {it_quo[24:0], 1'b1};
                it_rem = {it_diff, 1'b0};
            end else begin
                it_quo = {it_quo[24:0], 1'b0};
                it_rem = {it_rem[23:0], 1'b0};
            end
        end
    end

    logic [22:0]       frac_n;
    logic [23:0]       frac_r;
    logic signed [9:0] exp_n, exp_r;
    logic              guard, sticky, round_up, norm_ovf, norm_udf;
    logic [31:0]       norm_res;
    always_comb begin
        if (quo[25]) begin
            frac_n = quo[24:2];
            guard  = quo[1];
            sticky = quo[0] | (rem != '0);
            exp_n  = exp_t;
        end else begin
            frac_n = quo[23:1];
            guard  = quo[0];
            sticky = (rem != '0);
            exp_n  = exp_t - 10'sd1;
        end
        round_up = RNE_EN & guard & (sticky | frac_n[0]);
        frac_r   = {1'b0, frac_n} + {23'h0, round_up};
        exp_r    = frac_r[23] ? exp_n + 10'sd1 : exp_n;
        norm_res = '0;
        norm_ovf = 1'b0;
        norm_udf = 1'b0;
        if (exp_r >= 10'sd255) begin
            norm_res = {sign, 8'hFF, 23'h0};
            norm_ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            norm_res = {sign, 31'h0};
            norm_udf = 1'b1;
        end else begin
            norm_res = {sign, exp_r[7:0], frac_r[22:0]};
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = sp_hit ? DONE : DIVIDE;
            end
            DIVIDE:  if (cnt == 5'd1) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sign        <= 1'b0;
            exp_t       <= '0;
            mant_b      <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    sign   <= sp_sign;
                    exp_t  <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
                    mant_b <= {1'b1, data2[22:0]};
                    rem    <= it_rem;
                    quo    <= it_quo;
                    cnt    <= 5'(STEPS - 1);
                    if (sp_hit) begin
                        result      <= sp_res;
                        invalid     <= sp_inv;
                        div_by_zero <= sp_dbz;
                    end
                end
                DIVIDE: begin
                    rem <= it_rem;
                    quo <= it_quo;
                    cnt <= cnt - 5'd1;
                end
                NORM: begin
                    result    <= norm_res;
                    overflow  <= norm_ovf;
                    underflow <= norm_udf;
                end
                DONE: if (out_ready) begin
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= 1'b0;
                    invalid     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_div_seq.sv
// Bench for fp32_div_seq: directed vector table, handshake/reset corner sequences, randomized ops vs an integer-arithmetic model.
module tb_fp32_div_seq;
    localparam int          BPC      = 1;
    localparam int          LAT_NORM = 26 / BPC + 1;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
`ifdef FPU_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] data1 = '0, data2 = '0;
    logic        in_ready, out_valid, overflow, underflow, div_by_zero, invalid;
    logic [31:0] result;

    fp32_div_seq #(.BITS_PER_CYCLE(BPC), .QNAN(QNAN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Entered and left at #1 after a rising edge; completes the output handshake if out_ready is high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_wait: in_ready=0 want 1 within 100 cycles");
        end
        in_valid = 1'b1; data1 = a; data2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; data1 = $urandom; data2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        r = result;
        f = {overflow, underflow, div_by_zero, invalid};
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_valid_wait: out_valid=0 want 1 within 200 cycles");
        end else if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f, output int lat);
        logic        s, z1, z2, i1, i2, n1, n2, g, st;
        logic [7:0]  e1, e2;
        logic [63:0] num, den, q, rm;
        logic [24:0] mant;
        int          e;
        s  = a[31] ^ b[31];
        e1 = a[30:23]; e2 = b[30:23];
        z1 = (e1 == 0); z2 = (e2 == 0);
        i1 = (e1 == 255) && (a[22:0] == 0); i2 = (e2 == 255) && (b[22:0] == 0);
        n1 = (e1 == 255) && (a[22:0] != 0); n2 = (e2 == 255) && (b[22:0] != 0);
        r = '0; f = 4'b0000; lat = 1;
        if (n1 || n2)                      begin r = QNAN; f = 4'b0001; end
        else if ((z1 && z2) || (i1 && i2)) begin r = QNAN; f = 4'b0001; end
        else if (i1)                       r = {s, 8'hFF, 23'h0};
        else if (i2)                       r = {s, 31'h0};
        else if (z2)                       begin r = {s, 8'hFF, 23'h0}; f = 4'b0010; end
        else if (z1)                       r = {s, 31'h0};
        else begin
            lat = LAT_NORM;
            num = {40'h0, 1'b1, a[22:0]} << 25;
            den = {40'h0, 1'b1, b[22:0]};
            q   = num / den;
            rm  = num % den;
            e   = int'(e1) - int'(e2) + 127;
            if (q >= (64'd1 << 25)) begin
                mant = 25'(q >> 2); g = q[1]; st = q[0] || (rm != 0);
            end else begin
                e = e - 1;
                mant = 25'(q >> 1); g = q[0]; st = (rm != 0);
            end
            if (RNE && g && (st || mant[0])) mant = mant + 25'd1;
            if (mant[24]) begin mant = mant >> 1; e = e + 1; end
            if (e >= 255)     begin r = {s, 8'hFF, 23'h0}; f = 4'b1000; end
            else if (e <= 0)  begin r = {s, 31'h0}; f = 4'b0100; end
            else              r = {s, 8'(e), mant[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k = $urandom_range(0, 15);
        logic [31:0] v = $urandom;
        if (k == 0)      v[30:23] = 8'h00;
        else if (k == 1) begin v[30:23] = 8'hFF; v[22:0] = '0; end
        else if (k == 2) begin v[30:23] = 8'hFF; v[0] = 1'b1; end
        else if (k < 8)  v[30:23] = 8'($urandom_range(1, 254));
        else             v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat, elat;
        logic        seen;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_NORM};
        vecs[1]  = '{32'h3F800000, 32'h40400000, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 4'b0000, LAT_NORM};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1};
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1};
        vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, LAT_NORM};
        vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, LAT_NORM};
        vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1};
        vecs[7]  = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 1};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1};
        vecs[9]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1};
        vecs[10] = '{32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1};
        vecs[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, LAT_NORM};
        vecs[12] = '{32'h3F800000, 32'h807FFFFF, 32'hFF800000, 4'b0010, 1};
        vecs[13] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'h0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, r, f, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].flg));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure in DONE with a competing request on the input side.
        out_ready = 1'b0;
        run_op(32'h7F000000, 32'h3E800000, r, f, lat);
        check("bp_result", r, 32'h7F800000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; data1 = 32'h40C00000; data2 = 32'h40000000;
            @(posedge clk); #1;
            check("bp_hold_result", result, 32'h7F800000);
            check("bp_hold_flags", 32'({overflow, underflow, div_by_zero, invalid}), 32'h8);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        check("bp_no_ghost_accept", 32'(in_ready), 32'd1);

        // Reset in the middle of a normal divide.
        in_valid = 1'b1; data1 = 32'h40C00000; data2 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_abandoned", 32'(seen), 32'd0);
        run_op(32'h40C00000, 32'h40000000, r, f, lat);
        check("midrst_fresh_result", r, 32'h40400000);
        check("midrst_fresh_latency", 32'(lat), 32'(LAT_NORM));

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, b;
            a = rand_fp();
            b = rand_fp();
            if (i % 16 == 5) b = {$urandom_range(0, 1) == 1, a[30:0]};
            ref_div(a, b, er, ef, elat);
            run_op(a, b, r, f, lat);
            check($sformatf("rnd%0d_result(%h/%h)", i, a, b), r, er);
            check($sformatf("rnd%0d_flags", i), 32'(f), 32'(ef));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
